// File: rtl/hazard_pkg.sv
// Shared types for the operand hazard/forwarding unit.
// Slot layout and forwarding mux select encodings.
package hazard_pkg;

    localparam int NREG = 32;
    localparam int RW   = $clog2(NREG);

    localparam logic FWD_M  = 1'b0;
    localparam logic FWD_WB = 1'b1;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          wide;
        logic          load;
    } slot_t;

    // Tag 0 is the hardwired zero register and never matches.
    function automatic logic slot_hit(
        input slot_t         s,
        input logic          en,
        input logic [RW-1:0] rs
    );
        return s.valid && en &&
               (s.rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_if.sv
// EX-side control and forwarding-select bundle of the hazard unit.
// master = pipeline control, slave = hazard_unit.
interface hazard_if;
    import hazard_pkg::*;

    logic          hold;
    logic          flush;
    logic          ex_issue;
    logic          ex_wr;
    logic [RW-1:0] ex_rd;
    logic          ex_wide;
    logic          ex_load;
    logic          rs_a_en;
    logic          rs_b_en;
    logic [RW-1:0] rs_a;
    logic [RW-1:0] rs_b;
    logic          rs_a_wide;
    logic          rs_b_wide;
    logic          fwd_a_en;
    logic          fwd_b_en;
    logic          fwd_a_mode;
    logic          fwd_b_mode;
    logic          stall;

    modport master (
        output hold, flush,
        output ex_issue, ex_wr, ex_rd,
        output ex_wide, ex_load,
        output rs_a_en, rs_b_en,
        output rs_a, rs_b,
        output rs_a_wide, rs_b_wide,
        input  fwd_a_en, fwd_b_en,
        input  fwd_a_mode, fwd_b_mode,
        input  stall
    );

    modport slave (
        input  hold, flush,
        input  ex_issue, ex_wr, ex_rd,
        input  ex_wide, ex_load,
        input  rs_a_en, rs_b_en,
        input  rs_a, rs_b,
        input  rs_a_wide, rs_b_wide,
        output fwd_a_en, fwd_b_en,
        output fwd_a_mode, fwd_b_mode,
        output stall
    );

endinterface

// File: rtl/hazard_match.sv
// One operand's producer match, M-over-WB priority and stall decision.
// Instantiated once per ALU operand against the shared slots.
module hazard_match
    import hazard_pkg::*;
(
    input  slot_t         m_i,
    input  slot_t         wb_i,
    input  logic          en_i,
    input  logic [RW-1:0] rs_i,
    input  logic          wide_i,
    output logic          fwd_en_o,
    output logic          fwd_mode_o,
    output logic          stall_o
);

    logic m_hit;
    logic wb_hit;
    logic unused_wb_load;

    // A load in WB has its data, so its load flag no longer matters.
    assign unused_wb_load = wb_i.load;

    assign m_hit  = slot_hit(m_i, en_i, rs_i);
    assign wb_hit = slot_hit(wb_i, en_i, rs_i);

    always_comb begin
        fwd_en_o   = 1'b0;
        fwd_mode_o = FWD_M;
        stall_o    = 1'b0;
        unique case (1'b1)
            m_hit: begin
                if (m_i.load || (m_i.wide != wide_i)) begin
                    stall_o = 1'b1;
                end else begin
                    fwd_en_o = 1'b1;
                end
            end
            wb_hit && !m_hit: begin
                if (wb_i.wide != wide_i) begin
                    stall_o = 1'b1;
                end else begin
                    fwd_en_o   = 1'b1;
                    fwd_mode_o = FWD_WB;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// M/WB destination tracking, operand forwarding select and stall.
// HAZARD_STATS_EN adds forward/stall event counters.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    hazard_if.slave     hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] fwd_count,
    output logic [31:0] stall_count
`endif
);

    slot_t m_q;
    slot_t m_d;
    slot_t wb_q;
    slot_t wb_d;

    logic stall_a;
    logic stall_b;
    logic stall;

    hazard_match u_match_a (
        .m_i        (m_q),
        .wb_i       (wb_q),
        .en_i       (hz.rs_a_en),
        .rs_i       (hz.rs_a),
        .wide_i     (hz.rs_a_wide),
        .fwd_en_o   (hz.fwd_a_en),
        .fwd_mode_o (hz.fwd_a_mode),
        .stall_o    (stall_a)
    );

    hazard_match u_match_b (
        .m_i        (m_q),
        .wb_i       (wb_q),
        .en_i       (hz.rs_b_en),
        .rs_i       (hz.rs_b),
        .wide_i     (hz.rs_b_wide),
        .fwd_en_o   (hz.fwd_b_en),
        .fwd_mode_o (hz.fwd_b_mode),
        .stall_o    (stall_b)
    );

    assign stall    = stall_a | stall_b;
    assign hz.stall = stall;

    // A stalled or flushed EX instruction leaves a bubble in M.
    always_comb begin
        m_d  = m_q;
        wb_d = wb_q;
        if (!hz.hold) begin
            wb_d       = m_q;
            m_d.valid  = hz.ex_issue & hz.ex_wr &
                         ~hz.flush & ~stall;
            m_d.rd     = hz.ex_rd;
            m_d.wide   = hz.ex_wide;
            m_d.load   = hz.ex_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q  <= '0;
            wb_q <= '0;
        end else begin
            m_q  <= m_d;
            wb_q <= wb_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (!hz.hold) begin
            if (hz.fwd_a_en || hz.fwd_b_en) begin
                fwd_cnt_d = fwd_cnt_q + 32'd1;
            end
            if (stall) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_count   = fwd_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Tracks destination registers of instructions in the M and WB stages and drives the `mode` select of the forwarding mux for both ALU operands of the instruction in EX. Raises a pipeline stall when a forward is impossible: load result not yet available, or producer/consumer width mismatch. Sits between decode/EX control and the two operand forwarding muxes; holds its own M/WB tag pipeline registers.

## Interface
- `NREG`, 32: architectural register count; tag width `RW = $clog2(NREG)`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hold`  in  1  global freeze (memory busy); M/WB slots keep their contents.
- `flush`  in  1  kill instruction advancing from EX; M slot loads a bubble.
- `ex_issue`  in  1  instruction in EX advances to M this cycle.
- `ex_wr`  in  1  EX instruction writes a register.
- `ex_rd`  in  RW  EX destination tag.
- `ex_wide`  in  1  EX destination is 128-bit (1) or 32-bit (0).
- `ex_load`  in  1  EX instruction is a load; result valid only in WB.
- `rs_a_en`, `rs_b_en`  in  1  EX operand A/B reads a register.
- `rs_a`, `rs_b`  in  RW  EX operand source tags.
- `rs_a_wide`, `rs_b_wide`  in  1  operand width expected by consumer.
- `fwd_a_en`, `fwd_b_en`  out  1  use forwarded value instead of register file.
- `fwd_a_mode`, `fwd_b_mode`  out  1  forwarding mux select: 0 = M, 1 = WB.
- `stall`  out  1  hold EX/ID this cycle; insert bubble into M.

## Operation
- State: two slots, M and WB, each {valid, rd, wide, load}. Reset: both invalid.
- Advance (no `hold`): WB <= M; M <= {ex_issue & ex_wr & ~flush & ~stall, ex_rd, ex_wide, ex_load}.
- `hold` high: both slots frozen; `stall` and forward outputs still evaluated from current state.
- Match for an operand: slot valid, rs_en high, rs == slot.rd, rs != 0 (tag 0 hardwired zero, never forwarded).
- Priority: M match beats WB match (youngest producer wins).
- M match, M.load=0, width equal: fwd_en=1, mode=0.
- M match, M.load=1: stall=1, fwd_en=0 (load-use bubble; next cycle the load sits in WB and forwards with mode=1).
- Width mismatch on the selected producer: stall=1, fwd_en=0, until the producer has left WB and the register file supplies the value.
- WB match only, width equal: fwd_en=1, mode=1.
- No match: fwd_en=0, mode=0.
- `stall` = OR of both operands' stall conditions. A stalled EX instruction never enters M regardless of `ex_issue`.
- `flush` and `stall` together: bubble into M; WB still advances.

## Timing
- Forward outputs and `stall`: combinational from registered slots and current EX inputs, valid in the same cycle.
- Slot update latency: one cycle; an instruction issued in cycle n is in M at n+1 and in WB at n+2.
- Reset outputs: fwd_a_en = fwd_b_en = 0, modes 0, stall = 0. This is a consequence of invalid slots.
- `rst` asserted mid-operation overrides `hold`/`flush`; both slots invalid next cycle.

## Configuration
- `HAZARD_STATS_EN` defined: adds outputs `fwd_count` (32-bit, increments once per cycle in which either fwd_en is high and `hold` low) and `stall_count` (32-bit, increments per cycle with stall high and `hold` low). Both wrap at 2^32 and reset to 0.
- Undefined: counters and ports absent; behaviour otherwise identical.

## Structure
- Package `hazard_pkg`: `slot_t` struct {valid, rd, wide, load}, `FWD_M = 1'b0`, `FWD_WB = 1'b1`.
- Sub-module `hazard_match`: one operand's match/priority/stall logic. Instantiated twice (A, B) against the shared M/WB slots.

## Test plan
- Issue add r5 (32-bit); next cycle EX reads rs_a=5 -> fwd_a_en=1, fwd_a_mode=0, stall=0.
- Issue r5, then an unrelated instruction, then read rs_b=5 -> fwd_b_en=1, fwd_b_mode=1.
- Load r7, then immediately read rs_a=7 -> stall=1 for one cycle, then fwd_a_en=1, mode=1.
- Write r3 wide=1 in M and r3 wide=0 in WB; read r3 wide=1 -> mode=0 (M priority). Read r3 wide=0 -> stall until r3 leaves WB.
- Read rs_a=0 with an r0 writer in M -> fwd_a_en=0. Flush on issue of r9 -> later read of r9 gets fwd_b_en=0.
- `hold` for 3 cycles with r4 in M -> slots unchanged; with `HAZARD_STATS_EN`, counters frozen during hold; after `rst`, counters = 0 and all outputs 0.
